// File: rtl/toy_bus_ack_dec_demux_2.sv
// rtl/toy_bus_ack_dec_demux_2.sv - ToyBusAck 1:2 decode demux with per-output 2-entry FIFOs and drop counter
// Optional feature macro: TOY_BUS_ACK_DEC_BYPASS_EN (zero-latency bypass when an output FIFO is empty and ready)
module toy_bus_ack_dec_demux_2 #(
  parameter logic [3:0] OUT0_TGT_ID = 4'd0,
  parameter logic [3:0] OUT1_TGT_ID = 4'd1,
  parameter int         DROP_CNT_W  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_vld,
  output logic                  in_rdy,
  input  logic                  in_opcode,
  input  logic [255:0]          in_data,
  input  logic [31:0]           in_sideband,
  input  logic [3:0]            in_src_id,
  input  logic [3:0]            in_tgt_id,
  output logic                  out0_vld,
  input  logic                  out0_rdy,
  output logic                  out0_opcode,
  output logic [255:0]          out0_data,
  output logic [31:0]           out0_sideband,
  output logic [3:0]            out0_src_id,
  output logic [3:0]            out0_tgt_id,
  output logic                  out1_vld,
  input  logic                  out1_rdy,
  output logic                  out1_opcode,
  output logic [255:0]          out1_data,
  output logic [31:0]           out1_sideband,
  output logic [3:0]            out1_src_id,
  output logic [3:0]            out1_tgt_id,
  output logic                  drop_pulse,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // opcode + data + sideband + src_id + tgt_id
  localparam int PW = 297;

  logic [PW-1:0] w_in_pl;
  logic          w_sel0;
  logic          w_sel1;
  logic          w_miss;
  logic          w_acc;
  logic          w_byp0;
  logic          w_byp1;
  logic          w_push0;
  logic          w_push1;
  logic          w_pop0;
  logic          w_pop1;
  logic [PW-1:0] w_out0_pl;
  logic [PW-1:0] w_out1_pl;

  logic [PW-1:0] r_mem0 [2];
  logic [PW-1:0] r_mem1 [2];
  logic          r_wr0;
  logic          r_rd0;
  logic [1:0]    r_cnt0;
  logic          r_wr1;
  logic          r_rd1;
  logic [1:0]    r_cnt1;
  logic          r_drop_pulse;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  assign w_in_pl = {in_opcode, in_data, in_sideband, in_src_id, in_tgt_id};

  assign w_sel0 = (in_tgt_id == OUT0_TGT_ID);
  assign w_sel1 = (in_tgt_id == OUT1_TGT_ID);
  assign w_miss = ~w_sel0 & ~w_sel1;

  // Ready is a function of the routing key and FIFO occupancy only, never of in_vld.
  // A full FIFO refuses even if it pops this cycle.
  assign in_rdy = (w_sel0 & (r_cnt0 != 2'd2)) | (w_sel1 & (r_cnt1 != 2'd2)) | w_miss;
  assign w_acc  = in_vld & in_rdy;

`ifdef TOY_BUS_ACK_DEC_BYPASS_EN
  // An ack for an empty, ready output skips the FIFO and completes this cycle.
  assign w_byp0 = w_sel0 & (r_cnt0 == 2'd0) & out0_rdy;
  assign w_byp1 = w_sel1 & (r_cnt1 == 2'd0) & out1_rdy;
`else
  assign w_byp0 = 1'b0;
  assign w_byp1 = 1'b0;
`endif

  assign w_push0 = w_acc & w_sel0 & ~w_byp0;
  assign w_push1 = w_acc & w_sel1 & ~w_byp1;
  assign w_pop0  = (r_cnt0 != 2'd0) & out0_rdy;
  assign w_pop1  = (r_cnt1 != 2'd0) & out1_rdy;

  assign out0_vld  = (r_cnt0 != 2'd0) | (in_vld & w_byp0);
  assign out1_vld  = (r_cnt1 != 2'd0) | (in_vld & w_byp1);
  assign w_out0_pl = (r_cnt0 == 2'd0) ? w_in_pl : r_mem0[r_rd0];
  assign w_out1_pl = (r_cnt1 == 2'd0) ? w_in_pl : r_mem1[r_rd1];

  assign {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id} = w_out0_pl;
  assign {out1_opcode, out1_data, out1_sideband, out1_src_id, out1_tgt_id} = w_out1_pl;

  assign drop_pulse = r_drop_pulse;
  assign drop_cnt   = r_drop_cnt;

  // Payload storage for out0; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push0) r_mem0[r_wr0] <= w_in_pl;
  end

  // Payload storage for out1; intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push1) r_mem1[r_wr1] <= w_in_pl;
  end

  // out0 FIFO pointers and occupancy; push+pop at cnt=1 leaves cnt unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr0  <= 1'b0;
      r_rd0  <= 1'b0;
      r_cnt0 <= 2'd0;
    end else begin
      if (w_push0) r_wr0 <= ~r_wr0;
      if (w_pop0)  r_rd0 <= ~r_rd0;
      case ({w_push0, w_pop0})
        2'b10:   r_cnt0 <= r_cnt0 + 2'd1;
        2'b01:   r_cnt0 <= r_cnt0 - 2'd1;
        default: r_cnt0 <= r_cnt0;
      endcase
    end
  end

  // out1 FIFO pointers and occupancy; same rules as out0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr1  <= 1'b0;
      r_rd1  <= 1'b0;
      r_cnt1 <= 2'd0;
    end else begin
      if (w_push1) r_wr1 <= ~r_wr1;
      if (w_pop1)  r_rd1 <= ~r_rd1;
      case ({w_push1, w_pop1})
        2'b10:   r_cnt1 <= r_cnt1 + 2'd1;
        2'b01:   r_cnt1 <= r_cnt1 - 2'd1;
        default: r_cnt1 <= r_cnt1;
      endcase
    end
  end

  // Unmapped acks are swallowed: one pulse per drop and a counter that sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_pulse <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_drop_pulse <= w_acc & w_miss;
      if (w_acc & w_miss & (r_drop_cnt != {DROP_CNT_W{1'b1}}))
        r_drop_cnt <= r_drop_cnt + {{(DROP_CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_toy_bus_ack_dec_demux_2.sv
// tb/tb_toy_bus_ack_dec_demux_2.sv - self-checking bench for toy_bus_ack_dec_demux_2
module tb_toy_bus_ack_dec_demux_2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_vld;
  logic         in_rdy;
  logic         in_opcode;
  logic [255:0] in_data;
  logic [31:0]  in_sideband;
  logic [3:0]   in_src_id;
  logic [3:0]   in_tgt_id;
  logic         out0_vld, out0_rdy, out0_opcode;
  logic [255:0] out0_data;
  logic [31:0]  out0_sideband;
  logic [3:0]   out0_src_id, out0_tgt_id;
  logic         out1_vld, out1_rdy, out1_opcode;
  logic [255:0] out1_data;
  logic [31:0]  out1_sideband;
  logic [3:0]   out1_src_id, out1_tgt_id;
  logic         drop_pulse;
  logic [7:0]   drop_cnt;

  int checks = 0;
  int errors = 0;

  logic [296:0] q0[$];
  logic [296:0] q1[$];
  logic         exp_pulse = 1'b0;
  int           exp_cnt = 0;
  logic [255:0] pat_a5;

  toy_bus_ack_dec_demux_2 dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_opcode(in_opcode), .in_data(in_data),
    .in_sideband(in_sideband), .in_src_id(in_src_id), .in_tgt_id(in_tgt_id),
    .out0_vld(out0_vld), .out0_rdy(out0_rdy), .out0_opcode(out0_opcode), .out0_data(out0_data),
    .out0_sideband(out0_sideband), .out0_src_id(out0_src_id), .out0_tgt_id(out0_tgt_id),
    .out1_vld(out1_vld), .out1_rdy(out1_rdy), .out1_opcode(out1_opcode), .out1_data(out1_data),
    .out1_sideband(out1_sideband), .out1_src_id(out1_src_id), .out1_tgt_id(out1_tgt_id),
    .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [296:0] obs, input logic [296:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // One cycle: drive at negedge, check 1 ns later against the queue model, then advance the model.
  task automatic cyc(input logic vld, input logic [3:0] tgt, input logic [255:0] d,
                     input logic r0, input logic r1);
    logic [296:0] pl, ep0, ep1;
    logic s0, s1, ms, erdy, acc, b0, b1, ev0, ev1;
    in_vld = vld; in_tgt_id = tgt; in_data = d;
    in_opcode = 1'($urandom); in_sideband = $urandom; in_src_id = 4'($urandom);
    out0_rdy = r0; out1_rdy = r1;
    #1;
    pl   = {in_opcode, in_data, in_sideband, in_src_id, in_tgt_id};
    s0   = (tgt == 4'd0);
    s1   = (tgt == 4'd1);
    ms   = !s0 && !s1;
    erdy = ms || (s0 && q0.size() < 2) || (s1 && q1.size() < 2);
    acc  = vld && erdy;
    b0 = 1'b0;
    b1 = 1'b0;
`ifdef TOY_BUS_ACK_DEC_BYPASS_EN
    b0 = acc && s0 && q0.size() == 0 && r0;
    b1 = acc && s1 && q1.size() == 0 && r1;
`endif
    ev0 = (q0.size() != 0) || b0;
    ev1 = (q1.size() != 0) || b1;
    ep0 = b0 ? pl : ((q0.size() != 0) ? q0[0] : '0);
    ep1 = b1 ? pl : ((q1.size() != 0) ? q1[0] : '0);
    chk("in_rdy", 297'(in_rdy), 297'(erdy));
    chk("out0_vld", 297'(out0_vld), 297'(ev0));
    chk("out1_vld", 297'(out1_vld), 297'(ev1));
    if (ev0) chk("out0_payload", {out0_opcode, out0_data, out0_sideband, out0_src_id, out0_tgt_id}, ep0);
    if (ev1) chk("out1_payload", {out1_opcode, out1_data, out1_sideband, out1_src_id, out1_tgt_id}, ep1);
    chk("drop_pulse", 297'(drop_pulse), 297'(exp_pulse));
    chk("drop_cnt", 297'(drop_cnt), 297'(exp_cnt));
    if (q0.size() != 0 && r0) void'(q0.pop_front());
    if (q1.size() != 0 && r1) void'(q1.pop_front());
    if (acc && s0 && !b0) q0.push_back(pl);
    if (acc && s1 && !b1) q1.push_back(pl);
    exp_pulse = acc && ms;
    if (acc && ms && exp_cnt < 255) exp_cnt++;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] t;
    int         pick;
    rst_n = 1'b0;
    in_vld = 1'b0; in_opcode = 1'b0; in_data = '0; in_sideband = '0;
    in_src_id = '0; in_tgt_id = '0; out0_rdy = 1'b0; out1_rdy = 1'b0;
    for (int i = 0; i < 8; i++) pat_a5[i*32 +: 32] = 32'hA5A5A5A5;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out0_vld", 297'(out0_vld), 297'(1'b0));
    chk("rst_out1_vld", 297'(out1_vld), 297'(1'b0));
    chk("rst_drop_cnt", 297'(drop_cnt), 297'(8'd0));
    rst_n = 1'b1;
    @(negedge clk);
    cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Single ack to out0 with a recognisable pattern
    cyc(1'b1, 4'd0, pat_a5, 1'b1, 1'b1);
`ifndef TOY_BUS_ACK_DEC_BYPASS_EN
    #1;
    chk("a5_out0_vld", 297'(out0_vld), 297'(1'b1));
    chk("a5_out0_data", 297'(out0_data), 297'(pat_a5));
    chk("a5_out1_vld", 297'(out1_vld), 297'(1'b0));
`endif
    cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);
    cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // out0 backpressured: third tgt-0 ack refused, tgt-1 ack still flows
    repeat (3) cyc(1'b1, 4'd0, rnd256(), 1'b0, 1'b0);
    cyc(1'b1, 4'd1, rnd256(), 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Back-to-back alternating targets at full rate
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'(i % 2), rnd256(), 1'b1, 1'b1);
    repeat (2) cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);

    // Unmapped target 300 times: counter saturates at 255
    repeat (300) cyc(1'b1, 4'hF, rnd256(), 1'b1, 1'b1);
    cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);
    chk("drop_cnt_sat", 297'(drop_cnt), 297'(8'hFF));

    // Reset while out1 holds two acks
    repeat (2) cyc(1'b1, 4'd1, rnd256(), 1'b1, 1'b0);
    in_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out1_vld", 297'(out1_vld), 297'(1'b0));
    chk("midrst_drop_cnt", 297'(drop_cnt), 297'(8'd0));
    q0.delete(); q1.delete(); exp_pulse = 1'b0; exp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    repeat (3) cyc(1'b0, 4'd1, '0, 1'b1, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      pick = $urandom_range(3, 0);
      t = (pick == 0) ? 4'd0 : (pick == 1) ? 4'd1 : (pick == 2) ? 4'hF : 4'($urandom);
      cyc(1'($urandom), t, rnd256(), 1'($urandom), 1'($urandom));
    end
    repeat (3) cyc(1'b0, 4'd0, '0, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
